// File: rtl/axis_capture_sink_pkg.sv
// Shared types and helpers for the AXI-Stream capture sink.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package axis_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BACKOFF = 2'd1,
        ARMED   = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Callers zero-extend their keep vector to 64 bits.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    // Ready-arm threshold against an 8-bit random draw. 100% gives 256,
    // which the 9-bit compare always passes.
    function automatic logic [8:0] calc_thresh(input int unsigned prob);
        int unsigned t;
        t = (prob * 256) / 100;
        return t[8:0];
    endfunction

endpackage

// File: rtl/axis_lfsr_gate.sv
// Pseudo-random gate: 16-bit Galois LFSR compared against a percentage threshold.
// Latency: pass is combinational from the LFSR register, which advances every cycle.
// Backpressure: none; free-running.
// Ports: clk, rst (async active-high), pass (gate open this cycle).
module axis_lfsr_gate
    import axis_capture_pkg::*;
#(
    parameter int unsigned PROB_READY = 20,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
)(
    input  logic clk,
    input  logic rst,
    output logic pass
);

    localparam logic [8:0] THRESH = calc_thresh(PROB_READY);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pass = ({1'b0, lfsr_q[7:0]} < THRESH);

endmodule

// File: rtl/axis_capture_sink.sv
// AXI-Stream packet capture sink: compacts kept lanes into a word buffer with random ready gating.
// Latency: beat stored on its handshake edge; rd_data is registered, 1 cycle after rd_addr.
// Backpressure: s_ready is a flop, armed by an LFSR gate; dropped per beat (STREAM_MODE=0) or held to s_last (1).
// Ports: AXIS slave (s_valid/s_ready/s_last/s_keep/s_data), start, busy, pkt_done, pkt_words,
//        overflow, rd_addr/rd_data readback, proto_err.
// Optional: define AXIS_CAPTURE_SINK_PROTO_CHECK_EN to flag valid drop or payload change while stalled.
module axis_capture_sink
    import axis_capture_pkg::*;
#(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned BUS_W       = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned PROB_READY  = 20,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter bit          STREAM_MODE = 1'b0,
    localparam int unsigned WORDS_PER_BEAT = BUS_W / WORD_W
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    input  logic                             s_last,
    input  logic [WORDS_PER_BEAT-1:0]        s_keep,
    input  logic [WORDS_PER_BEAT*WORD_W-1:0] s_data,
    output logic                             s_ready,
    input  logic                             start,
    output logic                             busy,
    output logic                             pkt_done,
    output logic [$clog2(DEPTH):0]           pkt_words,
    output logic                             overflow,
    input  logic [$clog2(DEPTH)-1:0]         rd_addr,
    output logic [WORD_W-1:0]                rd_data,
    output logic                             proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e          state_q, state_d;
    logic            ready_q;
    logic            done_q, done_d;
    logic [CW-1:0]   words_q, words_d;
    logic            ovf_q, ovf_d;
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] mem [DEPTH];

    logic            gate_pass;
    logic            hs;
    logic            drop;
    logic [31:0]     words_sum;
    logic [CW-1:0]   words_sat;
    logic [WORDS_PER_BEAT-1:0]         lane_we;
    logic [WORDS_PER_BEAT-1:0][AW-1:0] lane_addr;

    axis_lfsr_gate #(
        .PROB_READY (PROB_READY),
        .LFSR_SEED  (LFSR_SEED)
    ) u_gate (
        .clk  (clk),
        .rst  (rst),
        .pass (gate_pass)
    );

    assign hs = s_valid && ready_q;

    // The write pointer is the saturated word count itself; it never exceeds DEPTH.
    assign words_sum = 32'(words_q) + popcount(64'(s_keep));
    assign words_sat = (words_sum > DEPTH) ? CW'(DEPTH) : words_sum[CW-1:0];

    // Kept lanes take consecutive slots in ascending lane order; slots past the end are dropped.
    always_comb begin
        logic [31:0] pos;
        pos       = 32'(words_q);
        drop      = 1'b0;
        lane_we   = '0;
        lane_addr = '0;
        for (int i = 0; i < WORDS_PER_BEAT; i++) begin
            lane_addr[i] = pos[AW-1:0];
            if (hs && s_keep[i]) begin
                if (pos < DEPTH) begin
                    lane_we[i] = 1'b1;
                end else begin
                    drop = 1'b1;
                end
                pos = pos + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = BACKOFF;
                    done_d  = 1'b0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            BACKOFF: begin
                if (gate_pass) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (hs) begin
                    words_d = words_sat;
                    if (drop) begin
                        ovf_d = 1'b1;
                    end
                    if (s_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (!STREAM_MODE) begin
                        state_d = BACKOFF;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            words_q   <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == ARMED);
            done_q    <= done_d;
            words_q   <= words_d;
            ovf_q     <= ovf_d;
            rd_data_q <= mem[rd_addr];
        end
    end

    // Buffer contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORDS_PER_BEAT; i++) begin
            if (lane_we[i]) begin
                mem[lane_addr[i]] <= s_data[i*WORD_W +: WORD_W];
            end
        end
    end

    assign s_ready   = ready_q;
    assign busy      = (state_q == BACKOFF) || (state_q == ARMED);
    assign pkt_done  = done_q;
    assign pkt_words = words_q;
    assign overflow  = ovf_q;
    assign rd_data   = rd_data_q;

`ifdef AXIS_CAPTURE_SINK_PROTO_CHECK_EN
    // A beat stalled at one edge must reappear unchanged at the next.
    logic                             stall_q;
    logic [WORDS_PER_BEAT*WORD_W-1:0] data_q;
    logic [WORDS_PER_BEAT-1:0]        keep_q;
    logic                             last_q;
    logic                             perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            stall_q <= s_valid && !ready_q;
            data_q  <= s_data;
            keep_q  <= s_keep;
            last_q  <= s_last;
            if (stall_q && (!s_valid || (s_data != data_q) || (s_keep != keep_q) || (s_last != last_q))) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: doc/axis_capture_sink.md
Name: axis_capture_sink

Overview:
Synthesizable AXI-Stream sink that captures one packet at a time into an internal word buffer. It compacts keep-qualified lanes into consecutive addresses and applies pseudo-random backpressure from an LFSR. It is a parametrised successor to the testbench pull-packet sink: buffer depth, streaming mode and readback are configurable, and it adds overflow and status reporting. It sits at the output of any DUT stream in bench or FPGA-loopback builds; software or the bench reads results through a synchronous read port.

Parameters:
WORD_W, 8, bits per word lane
BUS_W, 32, data bus width; must be a multiple of WORD_W
WORDS_PER_BEAT, BUS_W/WORD_W, lanes per beat (derived)
DEPTH, 256, capture buffer size in words; power of two, at least WORDS_PER_BEAT
PROB_READY, 20, percent chance (0..100) per cycle that ready is armed
LFSR_SEED, 16'hACE1, nonzero LFSR reset value
STREAM_MODE, 0, 0 = drop ready after each accepted beat; 1 = hold ready until s_last

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous reset, active-high
s_valid  in  1  AXIS valid
s_last  in  1  AXIS last
s_keep  in  WORDS_PER_BEAT  per-lane keep
s_data  in  WORDS_PER_BEAT x WORD_W  packed lane data; lane 0 is the LSBs
s_ready  out  1  AXIS ready, driven directly from a flop
start  in  1  pulse to arm capture of the next packet
busy  out  1  high in BACKOFF and ARMED
pkt_done  out  1  sticky; high from the cycle after the s_last handshake until the next start
pkt_words  out  $clog2(DEPTH)+1  words stored for the current packet
overflow  out  1  sticky; at least one kept word was dropped because the buffer was full
rd_addr  in  $clog2(DEPTH)  readback address
rd_data  out  WORD_W  buffer word at rd_addr, registered, 1-cycle latency
proto_err  out  1  sticky protocol violation flag (see Optional Feature)

Behaviour:
- Reset values: s_ready=0, busy=0, pkt_done=0, pkt_words=0, overflow=0, rd_data=0, proto_err=0, state=IDLE, LFSR=LFSR_SEED. Buffer contents are not reset.
- The LFSR is a 16-bit Galois LFSR with taps 16,14,13,11 and advances every cycle. The gate passes when {1'b0,lfsr[7:0]} < THRESH, with THRESH=(PROB_READY*256)/100 held at 9 bits. PROB_READY=100 always passes; PROB_READY=0 never passes.
- IDLE: s_ready=0. start -> BACKOFF. This clears pkt_done, pkt_words, overflow and the write pointer.
- BACKOFF: s_ready=0. Gate pass -> ARMED (s_ready=1 from the next cycle).
- ARMED: s_ready=1. A handshake is s_valid&&s_ready sampled at the rising edge.
  - On a handshake, lanes with keep=1 are written in ascending lane order to buffer[wptr..]. wptr and pkt_words advance by popcount(s_keep) in that same edge.
  - Words that would land at index ≥ DEPTH are dropped and set overflow. pkt_words saturates at DEPTH. There is no wrap-around.
  - A beat with keep=0 is accepted and stores nothing.
  - Handshake with s_last=1 -> DONE: s_ready=0 next cycle, pkt_done=1.
  - Handshake without s_last: STREAM_MODE=0 -> BACKOFF (s_ready drops for at least 1 cycle); STREAM_MODE=1 -> stay ARMED.
  - No handshake -> stay ARMED.
- DONE: s_ready=0; outputs hold. start -> BACKOFF with the same clears as from IDLE.
- start while busy is ignored.
- Readback on rd_addr is valid in any state. A read of an address written in the same edge returns the old value.
- Asserting rst mid-packet drops the packet immediately. Any beat on the bus at that point is not accepted.

Optional Feature:
- Macro: AXIS_CAPTURE_SINK_PROTO_CHECK_EN.
- When defined, proto_err is set (sticky until rst) if, while s_valid=1 && s_ready=0 at edge N, edge N+1 sees either:
  - s_valid=0, or
  - any change in s_data, s_keep or s_last.
- Input values are registered for this comparison.
- When not defined, proto_err is tied to 0 and no comparison registers exist.

Decomposition:
- Package axis_capture_pkg holds:
  - state enum {IDLE, BACKOFF, ARMED, DONE}
  - LFSR tap constant
  - popcount function over WORDS_PER_BEAT bits
  - THRESH calculation function
- Sub-module axis_lfsr_gate (params PROB_READY, LFSR_SEED; ports clk, rst, pass) holds the LFSR and threshold compare.

Test Plan:
- PROB_READY=100, STREAM_MODE=1, 4-beat packet, all keep=4'hF, data 0..15, last on beat 4: accepted in 4 consecutive cycles; pkt_words=16; buffer[0..15]=0..15; pkt_done=1.
- Beat keep=4'b0101 with data {D,C,B,A}, then keep=4'b1000 with {H,G,F,E} and last: buffer[0..2]=A,C,H; pkt_words=3.
- DEPTH=8: 3 full beats (12 words): buffer[0..7] = first 8 words; pkt_words=8; overflow=1; packet still completes with pkt_done=1.
- PROB_READY=20, STREAM_MODE=0, valid held high for a 50-beat packet: s_ready is never high on two consecutive cycles; all 200 words are captured in order; about 20% arm rate measured over 10k cycles (±5%).
- rst asserted mid-packet after 2 beats, then start and a fresh 1-beat packet: all outputs return to 0 immediately; the new packet lands at buffer[0..3]; pkt_words=4.
- With AXIS_CAPTURE_SINK_PROTO_CHECK_EN defined, change s_data while valid=1 and ready=0: proto_err=1 the next cycle and stays high until rst. Without the macro, proto_err stays 0.
